mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory/writeback stage of the 3-stage Riscv151 pipeline; sits directly downstream of the execute stage.
- Drives the data-cache request from execute-stage results and registers the instruction into writeback.
- Aligns and extends synchronous dcache read data, then produces the register-file write port.
- Owns the tohost CSR (0x51E) register and a sticky misalignment flag.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- CSR_RESET, 32'h0, reset value of the csr output.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- stall  input  1  memory-system stall; freezes this stage.
- ex_valid  input  1  execute-stage slot holds a live (not flushed) instruction.
- ex_pc  input  32  execute-stage PC.
- ex_alu_result  input  32  ALU result / effective address.
- ex_store_data  input  32  rs2 value for stores.
- ex_funct3  input  3  load/store size and sign.
- ex_is_load  input  1  load instruction.
- ex_is_store  input  1  store instruction.
- ex_reg_we  input  1  instruction writes rd.
- ex_rd  input  5  destination register.
- ex_wb_sel  input  2  writeback source: 0 ALU, 1 memory, 2 PC+4, 3 ALU.
- ex_csr_we  input  1  CSRRW/CSRRWI targeting 0x51E.
- ex_csr_wdata  input  32  CSR write value.
- dcache_addr  output  32  word address.
- dcache_re  output  1  read enable.
- dcache_we  output  4  byte write enables.
- dcache_din  output  32  write data, lane-shifted.
- dcache_dout  input  32  read data, valid one cycle after the request.
- wb_we  output  1  register-file write enable.
- wb_rd  output  5  register-file write address.
- wb_data  output  32  register-file write data.
- csr  output  32  tohost CSR.
- misalign_err  output  1  sticky misaligned-access flag.

Behaviour:
- Request side (combinational from ex_* inputs):
  - dcache_addr = {ex_alu_result[31:2], 2'b00}.
  - Misaligned when: halfword (funct3[1:0]=01) and addr[0]=1; or word (10) and addr[1:0]!=0.
  - dcache_re = ex_valid & ex_is_load & !misaligned.
  - dcache_we: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
  - dcache_we is gated by ex_valid & ex_is_store & !misaligned; otherwise 0.
  - dcache_din = ex_store_data << (8*addr[1:0]).
- Stall:
  - While stall=1, request outputs follow their inputs unchanged (upstream holds them).
  - No internal register updates while stall=1; the csr output holds.
- Writeback register: captured on each rising edge with stall=0. Fields:
  - valid = ex_valid & !(misaligned & (ex_is_load | ex_is_store)).
  - rd, reg_we, wb_sel, funct3, addr[1:0], alu_result, pc+4.
- Writeback outputs (latency 1 cycle after capture):
  - wb_we = valid & reg_we & (rd!=0).
  - wb_rd = rd.
  - wb_data by wb_sel:
    - ALU: alu_result.
    - PC+4: pc+4 (mod 2^32).
    - Memory: dcache_dout shifted right by 8*offset, then LB/LH sign-extended, LBU/LHU zero-extended, LW passthrough.
  - wb_data for funct3 = 011, 110 or 111 is 0.
- CSR: csr <= ex_csr_wdata on an edge with ex_valid & ex_csr_we & !stall.
- Sticky flag: misalign_err <= 1 on an edge with ex_valid & (ex_is_load|ex_is_store) & misaligned & !stall. Cleared only by reset.
- Reset (synchronous):
  - Writeback register: valid=0, all fields 0.
  - csr = CSR_RESET; misalign_err = 0.
  - wb_we = 0 one cycle after reset is sampled.
  - Request outputs remain combinational; they are 0 when ex_valid=0.
- Reset has priority over stall. Reset mid-stall discards the held instruction.
- A store never writes a register even if ex_reg_we=1 is presented: store has wb_sel don't-care and reg_we is forced to 0.

Optional Feature:
- Macro: MEM_WB_INSTRET_EN.
- Defined:
  - Adds output instret, 32 bits, reset 0.
  - Increments on each edge with stall=0 and registered valid=1; wraps 32'hFFFFFFFF -> 0.
- Undefined: port absent; no counter logic.

Test Plan:
- SW addr=0x104, data=0xDEADBEEF -> dcache_we=4'b1111, dcache_addr=0x104, dcache_din=0xDEADBEEF; wb_we=0 next cycle.
- SB addr=0x103, data=0x000000AB -> dcache_we=4'b1000, dcache_din=0xAB000000.
- Byte loads from addr=0x102 with dcache_dout=0x80FF7F01 -> next cycle:
  - LB: wb_data=0xFFFFFFFF.
  - LBU: wb_data=0x000000FF.
- LH from addr=0x102 -> wb_data=0xFFFF80FF.
- LW from addr=0x101 -> dcache_re=0, misalign_err=1 after the edge; wb_we=0; flag persists until reset.
- JAL in slot, ex_pc=0xFFFFFFFC, wb_sel=2, rd=1 -> wb_data=0x00000000, wb_we=1.
- Same slot with rd=0 -> wb_we=0.
- CSR write 0x1 with stall=1 for 3 cycles -> csr stays 0 and writeback registers hold; csr=0x1 on the first edge with stall=0.
- Assert reset mid-stall -> wb_we=0 and csr=0 after one edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage of the 3-stage Riscv151 pipeline.
//
// Purpose:
//   Drives the data-cache request from execute-stage results. Registers the
//   instruction into writeback. Aligns and extends the synchronous dcache read
//   data, and produces the register-file write port. Also owns the tohost CSR
//   (0x51E) and a sticky misaligned-access flag.
//
// Optional feature (macro MEM_WB_INSTRET_EN):
//   When defined, adds a 32-bit retired-instruction counter output 'instret'.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall             memory-system stall, freezes all state in this stage
//   ex_*              execute-stage instruction fields
//   dcache_addr/re/we/din   combinational data-cache request
//   dcache_dout       dcache read data, valid one cycle after the request
//   wb_we/wb_rd/wb_data     register-file write port
//   csr               tohost CSR value
//   misalign_err      sticky misaligned-access flag
//   instret           retired-instruction counter (MEM_WB_INSTRET_EN only)
module mem_wb_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] CSR_RESET = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic            ex_reg_we,
  input  logic [4:0]      ex_rd,
  input  logic [1:0]      ex_wb_sel,
  input  logic            ex_csr_we,
  input  logic [XLEN-1:0] ex_csr_wdata,
  output logic [XLEN-1:0] dcache_addr,
  output logic            dcache_re,
  output logic [3:0]      dcache_we,
  output logic [XLEN-1:0] dcache_din,
  input  logic [XLEN-1:0] dcache_dout,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] csr,
  output logic            misalign_err
`ifdef MEM_WB_INSTRET_EN
  ,
  output logic [XLEN-1:0] instret
`endif
);

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;

  logic [1:0] offset;
  logic       misaligned;
  logic       mem_bad;
  logic [3:0] byte_mask;

  logic            valid_q,  valid_d;
  logic            reg_we_q, reg_we_d;
  logic [4:0]      rd_q,     rd_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] alu_q,    alu_d;
  logic [XLEN-1:0] pc4_q,    pc4_d;
  logic [XLEN-1:0] csr_q,    csr_d;
  logic            err_q,    err_d;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  // Request side: purely combinational from the execute slot. Address and
  // write data are forced to zero for an empty slot so the bus is quiet.
  always_comb begin
    offset     = ex_alu_result[1:0];
    misaligned = 1'b0;
    byte_mask  = 4'b0000;
    case (ex_funct3[1:0])
      2'b00: byte_mask = 4'b0001 << offset;
      2'b01: begin
        byte_mask  = 4'b0011 << offset;
        misaligned = offset[0];
      end
      2'b10: begin
        byte_mask  = 4'b1111;
        misaligned = (offset != 2'b00);
      end
      default: byte_mask = 4'b0000;
    endcase
    mem_bad     = misaligned & (ex_is_load | ex_is_store);
    dcache_addr = ex_valid ? {ex_alu_result[XLEN-1:2], 2'b00} : '0;
    dcache_din  = ex_valid ? (ex_store_data << {offset, 3'b000}) : '0;
    dcache_re   = ex_valid & ex_is_load & ~misaligned;
    dcache_we   = (ex_valid & ex_is_store & ~misaligned) ? byte_mask : 4'b0000;
  end

  // Next state for the writeback register, CSR and sticky flag. Everything
  // holds while stalled. Stores never write a register, whatever reg_we says.
  always_comb begin
    valid_d  = valid_q;
    reg_we_d = reg_we_q;
    rd_d     = rd_q;
    wb_sel_d = wb_sel_q;
    funct3_d = funct3_q;
    alu_d    = alu_q;
    pc4_d    = pc4_q;
    csr_d    = csr_q;
    err_d    = err_q;
    if (!stall) begin
      valid_d  = ex_valid & ~mem_bad;
      reg_we_d = ex_reg_we & ~ex_is_store;
      rd_d     = ex_rd;
      wb_sel_d = ex_wb_sel;
      funct3_d = ex_funct3;
      alu_d    = ex_alu_result;
      pc4_d    = ex_pc + 32'd4;
      if (ex_valid && ex_csr_we) csr_d = ex_csr_wdata;
      if (ex_valid && mem_bad)   err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      rd_q     <= '0;
      wb_sel_q <= '0;
      funct3_q <= '0;
      alu_q    <= '0;
      pc4_q    <= '0;
      csr_q    <= CSR_RESET;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      reg_we_q <= reg_we_d;
      rd_q     <= rd_d;
      wb_sel_q <= wb_sel_d;
      funct3_q <= funct3_d;
      alu_q    <= alu_d;
      pc4_q    <= pc4_d;
      csr_q    <= csr_d;
      err_q    <= err_d;
    end
  end

  // Writeback side: the read data arrives this cycle, so lane alignment and
  // extension happen here using the captured byte offset and funct3.
  always_comb begin
    shifted = dcache_dout >> {alu_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
    case (wb_sel_q)
      SEL_MEM: wb_data = load_data;
      SEL_PC4: wb_data = pc4_q;
      SEL_ALU: wb_data = alu_q;
      default: wb_data = alu_q;
    endcase
    wb_we        = valid_q & reg_we_q & (rd_q != 5'd0);
    wb_rd        = rd_q;
    csr          = csr_q;
    misalign_err = err_q;
  end

`ifdef MEM_WB_INSTRET_EN
  logic [XLEN-1:0] instret_q, instret_d;

  // Counts instructions leaving writeback; wraps naturally at 2^32.
  always_comb begin
    instret_d = instret_q;
    if (!stall && valid_q) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed vectors, a behavioural model checked
// every cycle, and literal expectations at the key points of the test plan.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, ex_valid, ex_is_load, ex_is_store, ex_reg_we, ex_csr_we;
  logic [31:0] ex_pc, ex_alu_result, ex_store_data, ex_csr_wdata, dcache_dout;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [31:0] dcache_addr, dcache_din, wb_data, csr;
  logic        dcache_re, wb_we, misalign_err;
  logic [3:0]  dcache_we;
  logic [4:0]  wb_rd;
`ifdef MEM_WB_INSTRET_EN
  logic [31:0] instret;
`endif

  int compared   = 0;
  int mismatched = 0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_funct3(ex_funct3), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_reg_we(ex_reg_we), .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel),
    .ex_csr_we(ex_csr_we), .ex_csr_wdata(ex_csr_wdata),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .csr(csr), .misalign_err(misalign_err)
`ifdef MEM_WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, ld, st, rwe, cwe, stall, rst;
    logic [31:0] pc, alu, sdata, cdata, dout;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [1:0]  sel;
  } stim_t;

  stim_t cur;

  // Model state: what the writeback port and status outputs must show.
  bit          started = 0;
  logic        m_valid, m_we, m_err;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_pc4, m_csr, m_instret;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mkIdle();
    stim_t s;
    s.valid = 0; s.ld = 0; s.st = 0; s.rwe = 0; s.cwe = 0; s.stall = 0; s.rst = 0;
    s.pc = 0; s.alu = 0; s.sdata = 0; s.cdata = 0; s.dout = 0;
    s.f3 = 0; s.rd = 0; s.sel = 0;
    return s;
  endfunction

  function automatic stim_t mkMem(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] sdata, input logic [4:0] rd);
    stim_t s = mkIdle();
    s.valid = 1; s.ld = ld; s.st = !ld; s.f3 = f3; s.alu = addr; s.sdata = sdata;
    s.rd = rd; s.rwe = 1; s.sel = ld ? 2'd1 : 2'd0; s.pc = 32'h0000_1000;
    return s;
  endfunction

  function automatic stim_t mkAlu(input logic [31:0] pc, input logic [31:0] alu,
                                  input logic [4:0] rd, input logic [1:0] sel);
    stim_t s = mkIdle();
    s.valid = 1; s.pc = pc; s.alu = alu; s.rd = rd; s.rwe = 1; s.sel = sel;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    cur = s;
    reset = s.rst; stall = s.stall; ex_valid = s.valid; ex_pc = s.pc;
    ex_alu_result = s.alu; ex_store_data = s.sdata; ex_funct3 = s.f3;
    ex_is_load = s.ld; ex_is_store = s.st; ex_reg_we = s.rwe; ex_rd = s.rd;
    ex_wb_sel = s.sel; ex_csr_we = s.cwe; ex_csr_wdata = s.cdata; dcache_dout = s.dout;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #2;
    drive(s);
  endtask

  function automatic bit isMisaligned(input logic [2:0] f3, input logic [31:0] addr);
    if (f3[1:0] == 2'd1) return (addr % 2) != 0;
    if (f3[1:0] == 2'd2) return (addr % 4) != 0;
    return 0;
  endfunction

  task automatic reqModel(input stim_t s, output logic [31:0] a, output logic re,
                          output logic [3:0] we, output logic [31:0] din);
    int  off = int'(s.alu % 4);
    bit  bad = isMisaligned(s.f3, s.alu);
    a   = s.valid ? s.alu - (s.alu % 4) : 32'd0;
    din = s.valid ? s.sdata * (32'd1 << (8 * off)) : 32'd0;
    re  = s.valid && s.ld && !bad;
    we  = 4'd0;
    if (s.valid && s.st && !bad) begin
      case (s.f3[1:0])
        2'd0: we = 4'(1 << off);
        2'd1: we = 4'(3 << off);
        2'd2: we = 4'hF;
        default: we = 4'd0;
      endcase
    end
  endtask

  function automatic logic [31:0] loadValue(input logic [31:0] dout, input logic [31:0] addr,
                                            input logic [2:0] f3);
    logic [31:0] sh = dout / (32'd1 << (8 * (addr % 4)));
    logic [31:0] b  = sh % 256;
    logic [31:0] h  = sh % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd5: return h;
      3'd2: return sh;
      default: return 32'd0;
    endcase
  endfunction

  // Model update on each rising edge from the stimulus record.
  always @(posedge clk) begin
    if (cur.rst) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_sel = 0; m_f3 = 0; m_alu = 0; m_pc4 = 0;
      m_csr = 32'h0; m_err = 0; m_instret = 0; started = 1;
    end else if (!cur.stall) begin
      bit bad;
      if (m_valid) m_instret = m_instret + 1;
      bad     = isMisaligned(cur.f3, cur.alu) && (cur.ld || cur.st);
      m_valid = cur.valid && !bad;
      m_we    = m_valid && cur.rwe && !cur.st && cur.rd != 0;
      m_rd    = cur.rd; m_sel = cur.sel; m_f3 = cur.f3; m_alu = cur.alu;
      m_pc4   = cur.pc + 32'd4;
      if (cur.valid && cur.cwe) m_csr = cur.cdata;
      if (cur.valid && bad)     m_err = 1;
    end
  end

  // Compare process: every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (started) begin
      logic [31:0] ea, ed, exp_data;
      logic        ere;
      logic [3:0]  ewe;
      reqModel(cur, ea, ere, ewe, ed);
      checkOutput("dcache_addr", dcache_addr, ea);
      checkOutput("dcache_re", {31'd0, dcache_re}, {31'd0, ere});
      checkOutput("dcache_we", {28'd0, dcache_we}, {28'd0, ewe});
      checkOutput("dcache_din", dcache_din, ed);
      checkOutput("wb_we", {31'd0, wb_we}, {31'd0, m_we});
      checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
      checkOutput("csr", csr, m_csr);
      checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
`ifdef MEM_WB_INSTRET_EN
      checkOutput("instret", instret, m_instret);
`endif
      if (m_we) begin
        case (m_sel)
          2'd1:    exp_data = loadValue(cur.dout, m_alu, m_f3);
          2'd2:    exp_data = m_pc4;
          default: exp_data = m_alu;
        endcase
        checkOutput("wb_data", wb_data, exp_data);
      end
    end
  end

  initial begin
    stim_t s;
    s = mkIdle(); s.rst = 1;
    drive(s);
    applyStimulus(s);
    applyStimulus(s);
    #1;
    checkOutput("reset_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("reset_csr", csr, 32'h0);

    // SW with reg_we presented: must not write a register.
    applyStimulus(mkMem(0, 3'b010, 32'h104, 32'hDEADBEEF, 5'd3));
    #1;
    checkOutput("sw_we", {28'd0, dcache_we}, 32'hF);
    checkOutput("sw_addr", dcache_addr, 32'h104);
    checkOutput("sw_din", dcache_din, 32'hDEADBEEF);

    applyStimulus(mkMem(0, 3'b000, 32'h103, 32'h000000AB, 5'd4));
    #1;
    checkOutput("sw_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("sb_we", {28'd0, dcache_we}, 32'h8);
    checkOutput("sb_din", dcache_din, 32'hAB000000);

    // Byte/half loads from 0x102, data returned the following cycle.
    applyStimulus(mkMem(1, 3'b000, 32'h102, 32'h0, 5'd5));
    s = mkMem(1, 3'b100, 32'h102, 32'h0, 5'd6); s.dout = 32'h80FF7F01;
    applyStimulus(s);
    #1;
    checkOutput("lb_data", wb_data, 32'hFFFFFFFF);
    s = mkMem(1, 3'b001, 32'h102, 32'h0, 5'd7); s.dout = 32'h80FF7F01;
    applyStimulus(s);
    #1;
    checkOutput("lbu_data", wb_data, 32'h000000FF);
    s = mkMem(1, 3'b011, 32'h100, 32'h0, 5'd10); s.dout = 32'h80FF7F01;
    applyStimulus(s);
    #1;
    checkOutput("lh_data", wb_data, 32'hFFFF80FF);
    s = mkMem(0, 3'b001, 32'h106, 32'h0000CAFE, 5'd0); s.dout = 32'h12345678;
    applyStimulus(s);
    #1;
    checkOutput("ld011_data", wb_data, 32'h0);
    checkOutput("sh_din", dcache_din, 32'hCAFE0000);

    // Misaligned LW: no request, flag sets, no register write.
    applyStimulus(mkMem(1, 3'b010, 32'h101, 32'h0, 5'd8));
    #1;
    checkOutput("lw_mis_re", {31'd0, dcache_re}, 32'd0);
    applyStimulus(mkAlu(32'hFFFFFFFC, 32'h55, 5'd1, 2'd2));
    #1;
    checkOutput("lw_mis_err", {31'd0, misalign_err}, 32'd1);
    checkOutput("lw_mis_wb_we", {31'd0, wb_we}, 32'd0);

    // JAL at the top of memory: PC+4 wraps to zero.
    applyStimulus(mkAlu(32'hFFFFFFFC, 32'h55, 5'd0, 2'd2));
    #1;
    checkOutput("jal_data", wb_data, 32'h0);
    checkOutput("jal_wb_we", {31'd0, wb_we}, 32'd1);
    applyStimulus(mkAlu(32'h40, 32'h00000777, 5'd2, 2'd3));
    #1;
    checkOutput("jal_rd0_wb_we", {31'd0, wb_we}, 32'd0);

    // CSR write held by three stall cycles.
    s = mkIdle(); s.valid = 1; s.cwe = 1; s.cdata = 32'h1; s.stall = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s);
      #1;
      checkOutput("stall_csr", csr, 32'h0);
    end
    checkOutput("stall_hold_data", wb_data, 32'h00000777);
    s.stall = 0;
    applyStimulus(s);
    applyStimulus(mkIdle());
    #1;
    checkOutput("csr_after_stall", csr, 32'h1);
    checkOutput("err_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset while stalled discards the held instruction.
    applyStimulus(mkAlu(32'h200, 32'h1234, 5'd9, 2'd0));
    s = mkIdle(); s.stall = 1;
    applyStimulus(s);
    #1;
    checkOutput("pre_rst_wb_we", {31'd0, wb_we}, 32'd1);
    s.rst = 1;
    applyStimulus(s);
    applyStimulus(mkIdle());
    #1;
    checkOutput("rst_stall_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("rst_stall_csr", csr, 32'h0);
    checkOutput("rst_stall_err", {31'd0, misalign_err}, 32'd0);

    applyStimulus(mkIdle());
    applyStimulus(mkIdle());
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
